// File: rtl/ddram_pkg.sv
// Shared constants, state encoding and helpers for the DDRAM responder.
// Used by the interface, the RAM and the top-level responder.
package ddram_pkg;

    localparam int DDRAM_AW  = 29;
    localparam int DDRAM_DW  = 64;
    localparam int DDRAM_BEW = 8;

    localparam logic [DDRAM_AW-1:0] DDRAM_BASE_DEF = 29'h0C000000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WBURST,
        ST_RWAIT,
        ST_RDATA
    } ddram_state_e;

    // A burst count of zero behaves as a single beat.
    function automatic logic [7:0] burst_len(input logic [7:0] cnt);
        return (cnt == 8'd0) ? 8'd1 : cnt;
    endfunction

endpackage

// File: rtl/ddram_responder_if.sv
// MiSTer DDRAM Avalon-style port bundle.
// master = client side, slave = memory responder side.
interface ddram_responder_if;
    import ddram_pkg::*;

    logic                 DDRAM_BUSY;
    logic [7:0]           DDRAM_BURSTCNT;
    logic [DDRAM_AW-1:0]  DDRAM_ADDR;
    logic                 DDRAM_RD;
    logic                 DDRAM_WE;
    logic [DDRAM_DW-1:0]  DDRAM_DIN;
    logic [DDRAM_BEW-1:0] DDRAM_BE;
    logic [DDRAM_DW-1:0]  DDRAM_DOUT;
    logic                 DDRAM_DOUT_READY;

    modport master (
        input  DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
        output DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD,
        output DDRAM_WE, DDRAM_DIN, DDRAM_BE
    );

    modport slave (
        output DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
        input  DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD,
        input  DDRAM_WE, DDRAM_DIN, DDRAM_BE
    );

endinterface

// File: rtl/ddram_resp_mem.sv
// Single-clock 64-bit RAM with 8 byte-lane write enables and a
// registered read port. Contents are never reset.
module ddram_resp_mem
    import ddram_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [AW-1:0]        waddr_i,
    input  logic [DDRAM_DW-1:0]  wdata_i,
    input  logic [DDRAM_BEW-1:0] be_i,
    input  logic                 re_i,
    input  logic [AW-1:0]        raddr_i,
    output logic [DDRAM_DW-1:0]  rdata_o
);

    logic [DDRAM_DW-1:0] mem_q [2**AW];
    logic [DDRAM_DW-1:0] rdata_q;

    // Byte-lane gated write port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < DDRAM_BEW; i++) begin
                if (be_i[i]) begin
                    mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Registered read port; one cycle from address to data.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ddram_responder.sv
// DDRAM burst responder backed by on-chip RAM over a 2^ADDR_BITS window.
// Optional macro DDRAM_RESP_STALL_EN: LFSR-driven random BUSY stalls.
module ddram_responder
    import ddram_pkg::*;
#(
    parameter int                  ADDR_BITS    = 12,
    parameter logic [DDRAM_AW-1:0] BASE         = DDRAM_BASE_DEF,
    parameter int                  READ_LATENCY = 2
) (
    input  logic        DDRAM_CLK,
    input  logic        reset,
    ddram_responder_if.slave bus,
    output logic        proto_err
);

    localparam logic [2:0] LAT_INIT =
        3'(READ_LATENCY > 1 ? READ_LATENCY - 2 : 0);
    localparam logic [ADDR_BITS-1:0] OFF_ONE = ADDR_BITS'(1);

    ddram_state_e         state_q, state_d;
    logic [ADDR_BITS-1:0] off_q, off_d;
    logic [7:0]           remain_q, remain_d;
    logic [2:0]           lat_q, lat_d;
    logic                 win_q, win_d;
    logic                 busy_q, busy_d;
    logic                 perr_q, perr_d;

    logic                 busy;
    logic                 stall;
    logic [7:0]           burst_n;
    logic                 in_win;
    logic [ADDR_BITS-1:0] addr_off;

    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_waddr;
    logic                 mem_re;
    logic [ADDR_BITS-1:0] mem_raddr;
    logic [DDRAM_DW-1:0]  mem_rdata;

    assign burst_n  = burst_len(bus.DDRAM_BURSTCNT);
    assign addr_off = bus.DDRAM_ADDR[ADDR_BITS-1:0];
    assign in_win   = (bus.DDRAM_ADDR[DDRAM_AW-1:ADDR_BITS]
                       == BASE[DDRAM_AW-1:ADDR_BITS]);

`ifdef DDRAM_RESP_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, free-running.
    always_comb begin
        lfsr_d = {lfsr_q[14:0],
                  lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // LFSR state register, reseeded on reset.
    always_ff @(posedge DDRAM_CLK) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign stall = (lfsr_q[1:0] == 2'b00) &&
                   (state_q == ST_IDLE || state_q == ST_WBURST);
`else
    assign stall = 1'b0;
`endif

    assign busy = busy_q | stall;

    // Next-state, burst bookkeeping and RAM port control.
    always_comb begin
        state_d   = state_q;
        off_d     = off_q;
        remain_d  = remain_q;
        lat_d     = lat_q;
        win_d     = win_q;
        perr_d    = perr_q;
        mem_we    = 1'b0;
        mem_waddr = off_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!busy && bus.DDRAM_WE) begin
                    mem_we    = in_win;
                    mem_waddr = addr_off;
                    perr_d    = perr_q | bus.DDRAM_RD;
                    if (burst_n > 8'd1) begin
                        state_d  = ST_WBURST;
                        off_d    = addr_off + OFF_ONE;
                        remain_d = burst_n - 8'd1;
                        win_d    = in_win;
                    end
                end else if (!busy && bus.DDRAM_RD) begin
                    off_d    = addr_off;
                    remain_d = burst_n;
                    win_d    = in_win;
                    lat_d    = LAT_INIT;
                    if (READ_LATENCY == 1) begin
                        state_d = ST_RDATA;
                    end else begin
                        state_d = ST_RWAIT;
                    end
                end
            end
            ST_WBURST: begin
                if (bus.DDRAM_RD) begin
                    perr_d = 1'b1;
                end
                if (!busy && bus.DDRAM_WE) begin
                    mem_we   = win_q;
                    off_d    = off_q + OFF_ONE;
                    remain_d = remain_q - 8'd1;
                    if (remain_q == 8'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RWAIT: begin
                if (lat_q == 3'd0) begin
                    state_d = ST_RDATA;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            ST_RDATA: begin
                if (remain_q == 8'd1) begin
                    state_d = ST_IDLE;
                end else begin
                    off_d    = off_q + OFF_ONE;
                    remain_d = remain_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // RAM is read one cycle ahead so data lines up with RDATA.
        mem_re    = (state_d == ST_RDATA);
        mem_raddr = off_d;
        busy_d    = (state_d == ST_RWAIT) || (state_d == ST_RDATA);
    end

    // State and bookkeeping registers.
    always_ff @(posedge DDRAM_CLK) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            off_q    <= '0;
            remain_q <= '0;
            lat_q    <= '0;
            win_q    <= 1'b0;
            busy_q   <= 1'b1;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            off_q    <= off_d;
            remain_q <= remain_d;
            lat_q    <= lat_d;
            win_q    <= win_d;
            busy_q   <= busy_d;
            perr_q   <= perr_d;
        end
    end

    ddram_resp_mem #(
        .AW (ADDR_BITS)
    ) u_mem (
        .clk_i   (DDRAM_CLK),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (bus.DDRAM_DIN),
        .be_i    (bus.DDRAM_BE),
        .re_i    (mem_re),
        .raddr_i (mem_raddr),
        .rdata_o (mem_rdata)
    );

    assign bus.DDRAM_BUSY       = busy;
    assign bus.DDRAM_DOUT_READY = (state_q == ST_RDATA);
    assign bus.DDRAM_DOUT       = (state_q == ST_RDATA && win_q)
                                  ? mem_rdata : '0;
    assign proto_err            = perr_q;

endmodule

// File: tb/tb_ddram_responder.sv
// Self-checking bench for ddram_responder: table vectors, hand sequences,
// and a read scoreboard keyed on data and arrival cycle.
module tb_ddram_responder;
    import ddram_pkg::*;

    localparam int            AB = 12;
    localparam int            RL = 2;
    localparam logic [28:0]   BS = 29'h0C000000;

    typedef struct {
        logic [63:0] d;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [28:0] addr;
        logic [7:0]  be;
        logic [63:0] din;
        logic [63:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic proto_err;
    int   cyc = 0;
    int   errs = 0;
    int   checks = 0;

    exp_t        sbq[$];
    logic [63:0] mdl [int];

    ddram_responder_if bus();

    ddram_responder #(
        .ADDR_BITS    (AB),
        .BASE         (BS),
        .READ_LATENCY (RL)
    ) dut (
        .DDRAM_CLK (clk),
        .reset     (reset),
        .bus       (bus),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard: every DOUT_READY beat must match the queue head.
    always @(negedge clk) begin
        if (bus.DDRAM_DOUT_READY === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL unexpected_beat: got %h expected no beat",
                         bus.DDRAM_DOUT);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("rd_data", bus.DDRAM_DOUT, e.d);
                check("rd_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    function automatic bit in_win(input logic [28:0] a);
        return a[28:AB] == BS[28:AB];
    endfunction

    function automatic int woff(input logic [28:0] a, input int k);
        return (int'(a[AB-1:0]) + k) % (1 << AB);
    endfunction

    function automatic logic [63:0] mget(input int o);
        return mdl.exists(o) ? mdl[o] : 64'h0;
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old,
                                          input logic [63:0] nw,
                                          input logic [7:0] be);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++)
            if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    // Called at a negedge with command driven; returns at the negedge
    // after the accepting edge, e = cycle count seen there.
    task automatic wait_accept(input string nm, output int e);
        int k;
        k = 0;
        while (bus.DDRAM_BUSY !== 1'b0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (bus.DDRAM_BUSY !== 1'b0) begin
            errs++;
            $display("FAIL %s_accept: busy=%b after %0d cycles expected 0",
                     nm, bus.DDRAM_BUSY, k);
        end
        @(posedge clk);
        @(negedge clk);
        e = cyc;
    endtask

    task automatic wr(input logic [28:0] a, input int n,
                      input logic [7:0] be, input logic [63:0] d0,
                      input bit inc);
        int e;
        for (int i = 0; i < n; i++) begin
            bus.DDRAM_WE       = 1'b1;
            bus.DDRAM_ADDR     = a;
            bus.DDRAM_BURSTCNT = 8'(n);
            bus.DDRAM_DIN      = inc ? d0 + 64'(i) : d0;
            bus.DDRAM_BE       = be;
            wait_accept("wr", e);
            if (in_win(a))
                mdl[woff(a, i)] = merge(mget(woff(a, i)),
                                        bus.DDRAM_DIN, be);
        end
        bus.DDRAM_WE = 1'b0;
    endtask

    task automatic rd(input logic [28:0] a, input int n,
                      input bit use_exp, input logic [63:0] exp0);
        int   e;
        exp_t x;
        bus.DDRAM_RD       = 1'b1;
        bus.DDRAM_ADDR     = a;
        bus.DDRAM_BURSTCNT = 8'(n);
        bus.DDRAM_BE       = 8'h00;
        wait_accept("rd", e);
        bus.DDRAM_RD = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (use_exp && k == 0) x.d = exp0;
            else x.d = in_win(a) ? mget(woff(a, k)) : 64'h0;
            x.cyc = e + RL - 1 + k;
            sbq.push_back(x);
        end
        for (int j = 0; j < RL + n; j++) begin
            if (j > 0) @(negedge clk);
`ifdef DDRAM_RESP_STALL_EN
            if (j < RL + n - 1)
                check("rd_busy", 64'(bus.DDRAM_BUSY), 64'd1);
`else
            check("rd_busy", 64'(bus.DDRAM_BUSY),
                  64'(j < RL + n - 1));
`endif
        end
        check("rd_drain", 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time %0t expected finish earlier", $time);
        $fatal(1);
    end

    initial begin
        vec_t        tbl[8];
        logic [28:0] ra[100];
        int          e;

        tbl[0] = '{29'h0C000100, 8'hFF, 64'h1122334455667788,
                   64'h1122334455667788};
        tbl[1] = '{29'h0C000100, 8'h0F, 64'hAAAAAAAABBBBBBBB,
                   64'h11223344BBBBBBBB};
        tbl[2] = '{29'h0C000100, 8'h80, 64'hCC00000000000000,
                   64'hCC223344BBBBBBBB};
        tbl[3] = '{29'h0C000101, 8'hFF, 64'h0, 64'h0};
        tbl[4] = '{29'h0C000101, 8'h5A, 64'hFFFFFFFFFFFFFFFF,
                   64'h00FF00FFFF00FF00};
        tbl[5] = '{29'h00000100, 8'hFF, 64'hDEAD, 64'h0};
        tbl[6] = '{29'h0C000100, 8'h00, 64'hFFFFFFFFFFFFFFFF,
                   64'hCC223344BBBBBBBB};
        tbl[7] = '{29'h0C000FFF, 8'hFF, 64'h0123456789ABCDEF,
                   64'h0123456789ABCDEF};

        bus.DDRAM_RD       = 1'b0;
        bus.DDRAM_WE       = 1'b0;
        bus.DDRAM_ADDR     = '0;
        bus.DDRAM_BURSTCNT = 8'd1;
        bus.DDRAM_DIN      = '0;
        bus.DDRAM_BE       = '0;

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus.DDRAM_BUSY), 64'd1);
        check("rst_ready", 64'(bus.DDRAM_DOUT_READY), 64'd0);
        check("rst_dout", bus.DDRAM_DOUT, 64'h0);
        check("rst_perr", 64'(proto_err), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy_fall", 64'(bus.DDRAM_BUSY), 64'd0);

        // Single byte write then read back.
        wr(29'h0C000005, 1, 8'h01, 64'hAA, 1'b0);
        rd(29'h0C000005, 1, 1'b1, 64'h00000000000000AA);

        // Burst wraps at the top of the window.
        wr(29'h0C000FFE, 4, 8'hFF, 64'd1, 1'b1);
        rd(29'h0C000FFE, 4, 1'b0, 64'h0);
        rd(29'h0C000000, 1, 1'b1, 64'd3);
        rd(29'h0C000001, 1, 1'b1, 64'd4);
        rd(29'h0C000FFE, 1, 1'b1, 64'd1);

        // Out of window: writes dropped, reads return zero.
        wr(29'h00000005, 1, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        rd(29'h00000010, 2, 1'b0, 64'h0);
        rd(29'h00000005, 1, 1'b1, 64'h0);
        rd(29'h0C000005, 1, 1'b1, 64'h00000000000000AA);

        // Table of single-beat writes, each read straight back.
        for (int i = 0; i < 8; i++) begin
            wr(tbl[i].addr, 1, tbl[i].be, tbl[i].din, 1'b0);
            rd(tbl[i].addr, 1, 1'b1, tbl[i].exp);
        end

        // RD and WE together in IDLE.
        bus.DDRAM_RD       = 1'b1;
        bus.DDRAM_WE       = 1'b1;
        bus.DDRAM_ADDR     = 29'h0C000200;
        bus.DDRAM_BURSTCNT = 8'd1;
        bus.DDRAM_DIN      = 64'h55;
        bus.DDRAM_BE       = 8'hFF;
        wait_accept("rdwe", e);
        bus.DDRAM_RD = 1'b0;
        bus.DDRAM_WE = 1'b0;
        mdl[woff(29'h0C000200, 0)] = 64'h55;
        repeat (4) @(negedge clk);
        check("rdwe_perr", 64'(proto_err), 64'd1);
        rd(29'h0C000200, 1, 1'b1, 64'h55);
        check("rdwe_perr_sticky", 64'(proto_err), 64'd1);

        // Reset during an 8-beat read after three beats.
        wr(29'h0C000300, 8, 8'hFF, 64'h10, 1'b1);
        bus.DDRAM_RD       = 1'b1;
        bus.DDRAM_ADDR     = 29'h0C000300;
        bus.DDRAM_BURSTCNT = 8'd8;
        wait_accept("rst_rd", e);
        bus.DDRAM_RD = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_t x;
            x.d   = 64'h10 + 64'(k);
            x.cyc = e + RL - 1 + k;
            sbq.push_back(x);
        end
        repeat (RL + 1) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", 64'(bus.DDRAM_DOUT_READY), 64'd0);
        check("mid_rst_busy", 64'(bus.DDRAM_BUSY), 64'd1);
        check("mid_rst_beats", 64'(sbq.size()), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_busy_fall", 64'(bus.DDRAM_BUSY), 64'd0);
        check("mid_rst_perr", 64'(proto_err), 64'd0);
        repeat (10) @(negedge clk);
        rd(29'h0C000300, 8, 1'b0, 64'h0);
        rd(29'h0C000307, 1, 1'b1, 64'h17);

        // Random single-byte writes, then read all back.
        for (int i = 0; i < 100; i++) begin
            ra[i] = BS + 29'(12'h400 + 12'($urandom_range(0, 255)));
            wr(ra[i], 1, 8'(1 << $urandom_range(0, 7)),
               {$urandom, $urandom}, 1'b0);
        end
        for (int i = 0; i < 100; i++)
            rd(ra[i], 1, 1'b0, 64'h0);

        repeat (5) @(negedge clk);
        check("final_drain", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/ddram_responder.md
# ddram_responder

Synthesizable memory-side responder for the MiSTer DDRAM Avalon-style port: it accepts read/write bursts on the DDRAM_* signals and serves them from on-chip block RAM. It stands in for the HPS DDR3 controller in simulation and in small Multicomp builds, so DDRAM clients (8-bit CPU path, 32-bit SECD path) run unchanged without external memory. Only a window of the 29-bit word address space is backed; other addresses are answered but not stored.

## Interface
- ADDR_BITS, 12, backed depth in 64-bit words (4096 words = 32 KiB)
- BASE, 29'h0C000000, first word address of the backed window; must be aligned to 2^ADDR_BITS
- READ_LATENCY, 2, cycles from read-command acceptance to first data beat; legal range 1..8

- DDRAM_CLK  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- DDRAM_BUSY  out  1  command/beat not accepted this cycle
- DDRAM_BURSTCNT  in  8  burst length in beats; 0 treated as 1
- DDRAM_ADDR  in  29  64-bit word address, sampled on the first beat only
- DDRAM_RD  in  1  read command
- DDRAM_WE  in  1  write command / write beat
- DDRAM_DIN  in  64  write data
- DDRAM_BE  in  8  byte enables, bit i gates DIN[8i+7:8i]
- DDRAM_DOUT  out  64  read data
- DDRAM_DOUT_READY  out  1  DOUT valid this cycle
- proto_err  out  1  sticky protocol-violation flag, cleared only by reset

## Operation
- Transfer occurs on a cycle where (RD or WE) and not DDRAM_BUSY.
- States: IDLE, WBURST, RWAIT, RDATA.
- IDLE: WE accepted -> write beat 0 at ADDR, remaining = N-1; go WBURST if N>1 else stay. RD accepted -> latch ADDR, N; go RWAIT.
- WBURST: each accepted WE beat writes at next sequential address; after beat N-1 go IDLE. RD in WBURST: ignored, proto_err set.
- RWAIT: count READ_LATENCY-1 cycles, go RDATA (READ_LATENCY=1 goes straight to RDATA).
- RDATA: one beat per cycle, DOUT_READY high N consecutive cycles, addresses ADDR..ADDR+N-1; after last beat go IDLE.
- RD and WE together in IDLE: write performed, read dropped, proto_err set.
- Address in window: offset = ADDR-BASE, burst addresses wrap modulo 2^ADDR_BITS inside the window. Out of window: writes discarded, reads return 64'h0 with normal timing.
- Byte enables: only enabled lanes written; BE ignored for reads (full word returned).
- Memory contents are not cleared by reset; initial contents are zero.

## Timing
- Reset values: DDRAM_BUSY=1, DDRAM_DOUT_READY=0, DDRAM_DOUT=0, proto_err=0, state IDLE. BUSY falls in the first cycle after reset deasserts.
- Read accepted at cycle T: beats at T+READ_LATENCY .. T+READ_LATENCY+N-1; BUSY high T+1 .. T+READ_LATENCY+N-1, low at T+READ_LATENCY+N.
- Write: zero latency; a read accepted one cycle after the final write beat returns the new data (read-after-write coherent).
- BUSY low throughout IDLE and WBURST (unless stall injection); a held RD/WE simply waits while BUSY is high.
- Reset mid-burst: burst aborted, no further DOUT_READY; beats already written persist.

## Configuration
- DDRAM_RESP_STALL_EN defined: 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1, reset to seed) forces BUSY high in IDLE/WBURST whenever LFSR[1:0]==0, stressing client hold behaviour; LFSR advances every cycle.
- Undefined: BUSY depends only on reset and read state; no LFSR logic.

## Structure
- Package ddram_pkg: DDRAM_AW=29, DDRAM_DW=64, DDRAM_BEW=8, state enum, default window base constant.
- Sub-module ddram_resp_mem: single-clock, 8-lane byte-enable RAM, one write port, one registered read port; extra READ_LATENCY-1 alignment handled in the FSM.

## Test plan
- Write ADDR=29'h0C000005, BE=8'h01, DIN=64'hAA; read same, N=1 -> one beat DOUT=64'h00000000000000AA at T+2.
- Write burst N=4 at 29'h0C000FFE, DIN 1..4, BE=8'hFF -> words 0xFFE,0xFFF,0x000,0x001 hold 1,2,3,4 (wrap); read burst N=4 returns 1,2,3,4 on consecutive cycles.
- Read ADDR=29'h00000010 (out of window) N=2 -> two beats of 64'h0, no memory change, BUSY low at T+4.
- RD and WE asserted together in IDLE -> write done, no DOUT_READY, proto_err=1 until reset.
- Reset asserted during RDATA of N=8 after 3 beats -> no further DOUT_READY, BUSY=1 during reset, 0 one cycle after; prior data intact.
- With DDRAM_RESP_STALL_EN: 100 random single-byte writes then reads held across BUSY -> all reads match, no lost or duplicated beats.
